load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Initiator side of the data-memory interface. It accepts byte-addressed load/store requests from the execute stage and checks funct3 and alignment. It issues word-addressed transactions to the word-organised data memory, doing read-modify-write for SB/SH, and returns sign/zero-extended load data to writeback. It sits between the core pipeline and the data memory, which acknowledges each transaction with variable latency.

Parameters:
ADDR_WIDTH, 32, byte address width of core requests.
WORD_WIDTH, 32, data word width; fixed at 32 for lane logic.
TIMEOUT, 16, maximum cycles mem_req is held per memory phase before abort; must be >=1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
req_valid  input  1  core request valid.
req_ready  output  1  unit can accept a request; high only in IDLE.
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
req_addr  input  ADDR_WIDTH  byte address.
req_wdata  input  WORD_WIDTH  store data, right-aligned.
resp_valid  output  1  one-cycle response pulse.
resp_rdata  output  WORD_WIDTH  extended load data; 0 for stores and errors.
resp_err  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
mem_req  output  1  memory transaction request, held until ack.
mem_wen  output  1  1 = write phase.
mem_addr  output  ADDR_WIDTH-2  word index = req_addr[ADDR_WIDTH-1:2].
mem_wd  output  WORD_WIDTH  write word.
mem_rd  input  WORD_WIDTH  read word, valid with mem_ack in read phase.
mem_ack  input  1  memory completes the current phase this cycle.

Behaviour:
- States: IDLE, RD, WR, RESP. Reset (async, any state) -> IDLE. Every registered output and the internal latches clear to 0. req_ready = (state==IDLE), so it is 1 during and after reset.
- IDLE: on req_valid, latch we, funct3, addr and wdata.
  - Illegal funct3 (load 011/110/111; store >=011) -> RESP, err=10.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> RESP, err=01.
  - Illegal takes priority over misaligned.
  - No mem_req is issued for an error.
  - Otherwise: load, SB or SH -> RD; SW -> WR.
- RD: mem_req=1, mem_wen=0. On mem_ack, capture mem_rd.
  - Load -> RESP with extracted data. The lane is selected by addr[1:0] (byte) or addr[1] (half). LB/LH sign-extend; LBU/LHU zero-extend.
  - SB/SH -> WR. The captured word is merged with wdata[7:0] or wdata[15:0] into the addressed lane; the other lanes are preserved.
- WR: mem_req=1, mem_wen=1, mem_wd = wdata (SW) or the merged word. On mem_ack -> RESP.
- Timeout counter: cleared on entry to RD or WR. It increments on each RD/WR cycle without ack. If ack is absent while counter==TIMEOUT-1 -> RESP, err=11. An ack in that final cycle wins.
- A timeout in the RD phase of an RMW performs no write.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_err are valid only while resp_valid=1, and 0 otherwise.
- mem_req=0 outside RD/WR; mem_ack outside RD/WR is ignored. mem_addr and mem_wd are stable while mem_req=1.
- Latency, counting from the accept edge at T:
  - ack in the first cycle: load/SW resp at T+2; SB/SH resp at T+3.
  - error: resp at T+1.
- Back-to-back: a new request is accepted in the IDLE cycle following RESP. There is no overlap.

Test Plan:
- Reset mid-WR (mem_req high), assert rst asynchronously -> mem_req, resp_valid and the counter clear immediately; state returns to IDLE and req_ready=1.
- LB addr=0x103, mem_rd=0x80FF_1234 with ack in the first cycle -> resp_rdata=0xFFFF_FF80 at T+2; LBU same -> 0x0000_0080; LH addr=0x102 -> 0xFFFF_80FF.
- SB addr=0x101, wdata=0xAB, memory word 0x1122_3344 -> RD then WR with mem_wd=0x1122_AB44 and mem_addr=0x40; resp_err=00 at T+3.
- SW addr=0x8, wdata=0xDEAD_BEEF, ack delayed 3 cycles -> mem_req high for 4 cycles, mem_wen=1, single resp_valid pulse.
- LW addr=0x6 -> resp at T+1 with err=01 and no mem_req. Load funct3=011 -> err=10. SH addr=0x3 -> err=01.
- TIMEOUT=4 with mem_ack never asserted on SH -> mem_req high exactly 4 cycles, no WR phase, resp_err=11. An ack on the 4th cycle instead completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory initiator: checks funct3/alignment, issues word transactions
// (read-modify-write for SB/SH) and returns extended load data.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [WORD_WIDTH-1:0] resp_rdata,
    output logic [1:0]            resp_err,
    output logic                  mem_req,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wd,
    input  logic [WORD_WIDTH-1:0] mem_rd,
    input  logic                  mem_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0] wd_q, wd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_wen_q, mem_wen_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [WORD_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic [1:0]            resp_err_q, resp_err_d;

    logic                  illegal, misaligned;
    logic [1:0]            lane;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [WORD_WIDTH-1:0] load_data, merged;

    // Request checks look at the raw inputs so the decision is made on the accept edge
    always_comb begin
        illegal    = req_we ? (req_funct3 >= 3'b011)
                            : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    end

    always_comb begin
        lane    = addr_q[1:0];
        rd_byte = mem_rd[{lane, 3'b000} +: 8];
        rd_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'd0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = mem_rd;
        endcase
        merged = mem_rd;
        if (funct3_q[1:0] == 2'b00)
            merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wd_d         = wd_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_wen_d    = mem_wen_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata[15:0];
                    cnt_d    = '0;
                    if (illegal || misaligned) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = illegal ? 2'b10 : 2'b01;
                    end else if (req_we && req_funct3 == 3'b010) begin
                        state_d   = S_WR;
                        mem_req_d = 1'b1;
                        mem_wen_d = 1'b1;
                        wd_d      = req_wdata;
                    end else begin
                        state_d   = S_RD;
                        mem_req_d = 1'b1;
                        mem_wen_d = 1'b0;
                    end
                end
            end
            S_RD, S_WR: begin
                if (mem_ack) begin
                    cnt_d = '0;
                    if (state_q == S_RD && we_q) begin
                        state_d   = S_WR;
                        mem_wen_d = 1'b1;
                        wd_d      = merged;
                    end else begin
                        state_d      = S_RESP;
                        mem_req_d    = 1'b0;
                        mem_wen_d    = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = (state_q == S_RD) ? load_data : '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = S_RESP;
                    mem_req_d    = 1'b0;
                    mem_wen_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 2'b11;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wd_q         <= '0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wd_q         <= wd_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_wen_q    <= mem_wen_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = addr_q[ADDR_WIDTH-1:2];
    assign mem_wd     = wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a spec-level model predicts responses,
// write words and latencies; a responding memory with programmable ack delay.
module tb_load_store_unit;

    localparam int TO    = 4;
    localparam int NEVER = 99;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_req;
    logic        mem_wen;
    logic [29:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd = '0;
    logic        mem_ack = 1'b0;

    load_store_unit #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          cyc;
        int          reqs;
        int          base;
    } exp_t;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
    } wr_t;

    exp_t        expq[$];
    wr_t         wrq[$];
    logic [31:0] bmem[128];
    logic [31:0] ref_mem[128];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          req_total = 0;
    int          ack_delay = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Memory: acks the ack_delay-th cycle of each phase, random ack noise when idle
    initial begin : responder
        int  ph;
        bit  last_req, last_wen;
        ph = 0; last_req = 0; last_wen = 0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                if (!last_req || mem_wen != last_wen) ph = 0;
                else ph++;
                req_total++;
                if (ph == ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_wen) begin
                        if (wrq.size() == 0) begin
                            checkOutput("unexpected_write", {2'b00, mem_addr}, 32'hFFFF_FFFF);
                        end else begin
                            wr_t w;
                            w = wrq.pop_front();
                            checkOutput("wr_addr", {2'b00, mem_addr}, {2'b00, w.addr});
                            checkOutput("wr_data", mem_wd, w.data);
                        end
                        bmem[mem_addr[6:0]] = mem_wd;
                        mem_rd = $urandom;
                    end else begin
                        mem_rd = bmem[mem_addr[6:0]];
                    end
                end else begin
                    mem_ack = 1'b0;
                    mem_rd  = $urandom;
                end
            end else begin
                mem_ack = ($urandom_range(0, 3) == 0);
                mem_rd  = $urandom;
            end
            last_req = mem_req;
            last_wen = mem_wen;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (resp_valid) begin
                    if (expq.size() == 0) begin
                        checkOutput("unexpected_resp", {30'd0, resp_err}, 32'hFFFF_FFFF);
                    end else begin
                        e = expq.pop_front();
                        checkOutput("resp_err", {30'd0, resp_err}, {30'd0, e.err});
                        checkOutput("resp_rdata", resp_rdata, e.rdata);
                        checkOutput("resp_cycle", cyc, e.cyc);
                        checkOutput("mem_req_cycles", req_total - e.base, e.reqs);
                    end
                end else begin
                    checkOutput("idle_resp_zero", resp_rdata | {30'd0, resp_err}, 32'd0);
                end
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int dly);
        int          n, size, sh, lat, reqs, acc;
        bit          ill;
        logic [31:0] mask, word, v;
        exp_t        e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checkOutput("ready_timeout", {31'd0, req_ready}, 32'd1);
            return;
        end
        ack_delay  = dly;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc = cyc;

        ill  = we ? (f3 >= 3) : (f3 == 3 || f3 == 6 || f3 == 7);
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        sh   = 8 * (addr % 4);
        word = ref_mem[addr[8:2]];
        e.rdata = 32'd0;
        if (ill) begin
            e.err = 2'b10; lat = 1; reqs = 0;
        end else if (addr % size != 0) begin
            e.err = 2'b01; lat = 1; reqs = 0;
        end else if (dly >= TO) begin
            e.err = 2'b11; lat = 1 + TO; reqs = TO;
        end else begin
            e.err = 2'b00;
            if (we && size < 4) begin
                lat = 3 + 2 * dly; reqs = 2 * dly + 2;
            end else begin
                lat = 2 + dly; reqs = dly + 1;
            end
            if (!we) begin
                v = (word >> sh) & mask;
                if (f3 < 4 && size < 4 && v[size * 8 - 1]) v = v | ~mask;
                e.rdata = v;
            end else begin
                wr_t w;
                v = (size == 4) ? wdata : ((word & ~(mask << sh)) | ((wdata & mask) << sh));
                ref_mem[addr[8:2]] = v;
                w.addr = addr[31:2];
                w.data = v;
                wrq.push_back(w);
            end
        end
        e.cyc  = acc + lat - 1;
        e.reqs = reqs;
        e.base = req_total;
        expq.push_back(e);
    endtask

    initial begin : stimulus
        int          n, r, d;
        logic [31:0] a, v;
        for (int i = 0; i < 128; i++) begin
            v = $urandom;
            bmem[i] = v;
            ref_mem[i] = v;
        end
        bmem[64]    = 32'h80FF_1234;
        ref_mem[64] = 32'h80FF_1234;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the middle of a stalled write phase
        @(negedge clk);
        ack_delay  = NEVER;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'h1234_5678;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("mid_wr_mem_req", {31'd0, mem_req}, 32'd1);
        checkOutput("mid_wr_mem_wen", {31'd0, mem_wen}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("async_rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 0);
        applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 0);
        applyStimulus(1'b0, 3'b001, 32'h102, 32'h0, 0);
        applyStimulus(1'b1, 3'b010, 32'h100, 32'h1122_3344, 0);
        applyStimulus(1'b1, 3'b000, 32'h101, 32'h0000_00AB, 0);
        applyStimulus(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 3);
        applyStimulus(1'b0, 3'b010, 32'h6, 32'h0, 0);
        applyStimulus(1'b0, 3'b011, 32'h0, 32'h0, 0);
        applyStimulus(1'b1, 3'b001, 32'h3, 32'h0, 0);
        applyStimulus(1'b1, 3'b001, 32'h10, 32'hCAFE, NEVER);
        applyStimulus(1'b1, 3'b001, 32'h10, 32'hBEEF, TO - 1);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 0);
        applyStimulus(1'b0, 3'b101, 32'h102, 32'h0, 1);

        for (int i = 0; i < 300; i++) begin
            a = $urandom_range(0, 511);
            if ($urandom_range(0, 1) == 1) a = a & 32'h1FC;
            r = $urandom_range(0, 9);
            d = (r < 9) ? (r % TO) : NEVER;
            applyStimulus($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), a, $urandom, d);
        end

        n = 0;
        while ((expq.size() != 0 || wrq.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("drain_resp_queue", expq.size(), 32'd0);
        checkOutput("drain_write_queue", wrq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
